// File: rtl/video_pattern_gen.sv
// Programmable video timing generator with test patterns: sync/porch/active
// counters, a run/idle controller, and registered VSYNC/HSYNC/DEN/pixel outputs.
module video_pattern_gen #(
    parameter int PARAM_WIDTH = 16,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                   I_CLK,
    input  logic                   I_RST,
    input  logic                   i_enable,
    input  logic [PARAM_WIDTH-1:0] i_hsw,
    input  logic [PARAM_WIDTH-1:0] i_hbp,
    input  logic [PARAM_WIDTH-1:0] i_hact,
    input  logic [PARAM_WIDTH-1:0] i_hfp,
    input  logic [PARAM_WIDTH-1:0] i_vsw,
    input  logic [PARAM_WIDTH-1:0] i_vbp,
    input  logic [PARAM_WIDTH-1:0] i_vact,
    input  logic [PARAM_WIDTH-1:0] i_vfp,
    input  logic [1:0]             i_pattern_sel,
    input  logic [DATA_WIDTH-1:0]  i_solid_value,
    output logic                   O_VSYNC,
    output logic                   O_HSYNC,
    output logic                   O_DEN,
    output logic [DATA_WIDTH-1:0]  O_DATA,
    output logic                   o_frame_done,
    output logic                   o_param_err
);

    localparam int CW = PARAM_WIDTH + 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nx;

    logic [PARAM_WIDTH-1:0] hsw_q, hbp_q, hact_q, hfp_q;
    logic [PARAM_WIDTH-1:0] vsw_q, vbp_q, vact_q, vfp_q;
    logic [1:0]             pattern_q;
    logic [DATA_WIDTH-1:0]  solid_q;

    logic [CW-1:0] h_cnt, v_cnt;
    logic [CW-1:0] h_act_start, h_act_end, h_total;
    logic [CW-1:0] v_act_start, v_act_end, v_total;

    logic params_ok, line_end, frame_end, load, reject;
    logic hs_t, vs_t, den_t;
    logic [DATA_WIDTH-1:0] x_px, y_px, pixel;

    // Two extra bits keep the four-field sums from overflowing.
    assign h_act_start = CW'(hsw_q) + CW'(hbp_q);
    assign h_act_end   = h_act_start + CW'(hact_q);
    assign h_total     = h_act_end + CW'(hfp_q);
    assign v_act_start = CW'(vsw_q) + CW'(vbp_q);
    assign v_act_end   = v_act_start + CW'(vact_q);
    assign v_total     = v_act_end + CW'(vfp_q);

    assign params_ok = (i_hsw != '0) && (i_hact != '0) && (i_vsw != '0) && (i_vact != '0);
    assign line_end  = (h_cnt == h_total - CW'(1));
    assign frame_end = line_end && (v_cnt == v_total - CW'(1));

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        reject   = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable) begin
                    if (params_ok) begin
                        state_nx = RUN;
                        load     = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            RUN: begin
                if (frame_end) begin
                    if (i_enable && params_ok) begin
                        load = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        reject   = i_enable;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge I_CLK) begin
        if (I_RST) state <= IDLE;
        else       state <= state_nx;
    end

    // Timing fields are sampled only at start and frame wrap, so mid-frame edits wait a frame.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            hsw_q     <= '0;
            hbp_q     <= '0;
            hact_q    <= '0;
            hfp_q     <= '0;
            vsw_q     <= '0;
            vbp_q     <= '0;
            vact_q    <= '0;
            vfp_q     <= '0;
            pattern_q <= '0;
            solid_q   <= '0;
        end else if (load) begin
            hsw_q     <= i_hsw;
            hbp_q     <= i_hbp;
            hact_q    <= i_hact;
            hfp_q     <= i_hfp;
            vsw_q     <= i_vsw;
            vbp_q     <= i_vbp;
            vact_q    <= i_vact;
            vfp_q     <= i_vfp;
            pattern_q <= i_pattern_sel;
            solid_q   <= i_solid_value;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST || state != RUN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= frame_end ? '0 : v_cnt + CW'(1);
        end else begin
            h_cnt <= h_cnt + CW'(1);
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST)       o_param_err <= 1'b0;
        else if (reject) o_param_err <= 1'b1;
        else if (load)   o_param_err <= 1'b0;
    end

    assign hs_t  = (h_cnt < CW'(hsw_q));
    assign vs_t  = (v_cnt < CW'(vsw_q));
    assign den_t = (h_cnt >= h_act_start) && (h_cnt < h_act_end) &&
                   (v_cnt >= v_act_start) && (v_cnt < v_act_end);
    assign x_px  = DATA_WIDTH'(h_cnt - h_act_start);
    assign y_px  = DATA_WIDTH'(v_cnt - v_act_start);

    always_comb begin
        pixel = '0;
        case (pattern_q)
            2'd0:    pixel = solid_q;
            2'd1:    pixel = x_px;
            2'd2:    pixel = y_px;
            default: pixel = {DATA_WIDTH{x_px[3] ^ y_px[3]}};
        endcase
    end

    // Outputs lag the counters by exactly one cycle and are forced low outside RUN.
    always_ff @(posedge I_CLK) begin
        if (I_RST || state != RUN) begin
            O_HSYNC      <= 1'b0;
            O_VSYNC      <= 1'b0;
            O_DEN        <= 1'b0;
            O_DATA       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            O_HSYNC      <= hs_t;
            O_VSYNC      <= vs_t;
            O_DEN        <= den_t;
            O_DATA       <= den_t ? pixel : '0;
            o_frame_done <= frame_end;
        end
    end

endmodule
